// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern controller.
// Optional build macro: LED_PATTERN_GAMMA_EN (gamma-corrected PWM duty).
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } led_mode_t;

  localparam int DEF_NUM_LED    = 4;
  localparam int DEF_PWM_BITS   = 8;
  localparam int DEF_PRESCALE   = 16;
  localparam int DEF_BLINK_BITS = 16;

  // Widest duty the gamma helper handles.
  localparam int MAX_PWM_BITS   = 16;

  // Gamma-corrected duty: (duty*duty) >> bits. An all-ones duty stays
  // all-ones so full brightness is still reachable.
  function automatic logic [MAX_PWM_BITS-1:0] gamma_duty(
    input logic [MAX_PWM_BITS-1:0] duty,
    input int unsigned             bits
  );
    logic [2*MAX_PWM_BITS-1:0] sq;
    logic [2*MAX_PWM_BITS-1:0] full;
    logic [2*MAX_PWM_BITS-1:0] shifted;
    sq      = {{MAX_PWM_BITS{1'b0}}, duty} * {{MAX_PWM_BITS{1'b0}}, duty};
    full    = ({{(2*MAX_PWM_BITS-1){1'b0}}, 1'b1} << bits) - {{(2*MAX_PWM_BITS-1){1'b0}}, 1'b1};
    shifted = sq >> bits;
    if ({{MAX_PWM_BITS{1'b0}}, duty} == full) begin
      gamma_duty = duty;
    end else begin
      gamma_duty = shifted[MAX_PWM_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/led_pattern_chan.sv
// One LED channel: selects the on state from the active mode and the shared
// counters, and registers it.
module led_pattern_chan
  import led_pattern_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  led_mode_t           mode,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                phase,
  output logic                led_on
);

  logic on_s;
  logic led_on_r;

  // Mode mux: off / on / blink phase / PWM compare (all-ones duty is solid on).
  always_comb begin
    on_s = 1'b0;
    case (mode)
      MODE_OFF:   on_s = 1'b0;
      MODE_ON:    on_s = 1'b1;
      MODE_BLINK: on_s = phase;
      MODE_PWM:   on_s = (pwm_cnt < duty) || (duty == {PWM_BITS{1'b1}});
      default:    on_s = 1'b0;
    endcase
  end

  // Output register so the pin drive never sees combinational glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_on_r <= 1'b0;
    end else begin
      led_on_r <= on_s;
    end
  end

  assign led_on = led_on_r;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator. Host config is staged in pending
// registers and applied only at a PWM frame boundary.
// Optional build macro: LED_PATTERN_GAMMA_EN (gamma-correct duty at apply).
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int NUM_LED    = DEF_NUM_LED,
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int BLINK_BITS = DEF_BLINK_BITS
) (
  input  logic                         okClk,
  input  logic                         rst,
  input  logic [2*NUM_LED-1:0]         cfg_mode,
  input  logic [PWM_BITS*NUM_LED-1:0]  cfg_duty,
  input  logic [BLINK_BITS-1:0]        cfg_blink_half,
  input  logic                         cfg_update,
  output logic                         frame_start,
  output logic                         cfg_pending,
  output logic [NUM_LED-1:0]           led_on
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]            pre_cnt_r;
  logic [PWM_BITS-1:0]         pwm_cnt_r;
  logic [BLINK_BITS-1:0]       blink_cnt_r;
  logic                        phase_r;
  logic                        frame_start_r;
  logic                        cfg_pending_r;
  logic [2*NUM_LED-1:0]        pend_mode_r;
  logic [PWM_BITS*NUM_LED-1:0] pend_duty_r;
  logic [BLINK_BITS-1:0]       pend_half_r;
  logic [2*NUM_LED-1:0]        act_mode_r;
  logic [PWM_BITS*NUM_LED-1:0] act_duty_r;
  logic [BLINK_BITS-1:0]       act_half_r;

  logic                        tick_s;
  logic                        wrap_s;
  logic                        apply_s;
  logic [BLINK_BITS-1:0]       half_eff_s;
  logic [PWM_BITS*NUM_LED-1:0] act_duty_next_s;

  assign tick_s     = (pre_cnt_r == PRE_W'(PRESCALE - 1));
  assign wrap_s     = tick_s && (pwm_cnt_r == {PWM_BITS{1'b1}});
  assign apply_s    = wrap_s && cfg_pending_r;
  // A zero half-period behaves as one tick.
  assign half_eff_s = (act_half_r == {BLINK_BITS{1'b0}}) ? BLINK_BITS'(1) : act_half_r;

`ifdef LED_PATTERN_GAMMA_EN
  logic [MAX_PWM_BITS-1:0] gamma_s;

  // Gamma-correct every pending duty so the active register holds the
  // corrected value and the per-channel compare stays a plain comparison.
  always_comb begin
    act_duty_next_s = pend_duty_r;
    gamma_s         = {MAX_PWM_BITS{1'b0}};
    for (int i = 0; i < NUM_LED; i++) begin
      gamma_s = gamma_duty(MAX_PWM_BITS'(pend_duty_r[i*PWM_BITS +: PWM_BITS]), PWM_BITS);
      act_duty_next_s[i*PWM_BITS +: PWM_BITS] = gamma_s[PWM_BITS-1:0];
    end
  end
`else
  // Linear duty: the pending value is used as-is.
  always_comb begin
    act_duty_next_s = pend_duty_r;
  end
`endif

  // Prescaler: tick on the last count of each PRESCALE-cycle period.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else if (tick_s) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_W'(1);
    end
  end

  // PWM counter and registered frame-boundary pulse.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      pwm_cnt_r     <= {PWM_BITS{1'b0}};
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= wrap_s;
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      end else begin
        pwm_cnt_r <= pwm_cnt_r;
      end
    end
  end

  // Capture into pending; a capture on the apply cycle keeps pending set so
  // the new values go out at the following frame.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      pend_mode_r   <= {(2*NUM_LED){1'b0}};
      pend_duty_r   <= {(PWM_BITS*NUM_LED){1'b0}};
      pend_half_r   <= {BLINK_BITS{1'b0}};
      cfg_pending_r <= 1'b0;
    end else if (cfg_update) begin
      pend_mode_r   <= cfg_mode;
      pend_duty_r   <= cfg_duty;
      pend_half_r   <= cfg_blink_half;
      cfg_pending_r <= 1'b1;
    end else if (apply_s) begin
      cfg_pending_r <= 1'b0;
    end else begin
      cfg_pending_r <= cfg_pending_r;
    end
  end

  // Active registers load from pending only at a frame boundary.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      act_mode_r <= {(2*NUM_LED){1'b0}};
      act_duty_r <= {(PWM_BITS*NUM_LED){1'b0}};
      act_half_r <= {BLINK_BITS{1'b0}};
    end else if (apply_s) begin
      act_mode_r <= pend_mode_r;
      act_duty_r <= act_duty_next_s;
      act_half_r <= pend_half_r;
    end else begin
      act_mode_r <= act_mode_r;
    end
  end

  // Blink timer: restarts high on apply, toggles every half-period of ticks.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= {BLINK_BITS{1'b0}};
      phase_r     <= 1'b1;
    end else if (apply_s) begin
      blink_cnt_r <= {BLINK_BITS{1'b0}};
      phase_r     <= 1'b1;
    end else if (tick_s) begin
      if (blink_cnt_r == (half_eff_s - BLINK_BITS'(1))) begin
        blink_cnt_r <= {BLINK_BITS{1'b0}};
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_BITS'(1);
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
    end
  end

  assign frame_start = frame_start_r;
  assign cfg_pending = cfg_pending_r;

  for (genvar g = 0; g < NUM_LED; g++) begin : g_chan
    led_pattern_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk     (okClk),
      .rst     (rst),
      .mode    (led_mode_t'(act_mode_r[2*g +: 2])),
      .duty    (act_duty_r[g*PWM_BITS +: PWM_BITS]),
      .pwm_cnt (pwm_cnt_r),
      .phase   (phase_r),
      .led_on  (led_on[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl (NUM_LED=4, PWM_BITS=4, PRESCALE=2,
// BLINK_BITS=8). A timeline model derives expected outputs from elapsed edges.
module tb_led_pattern_ctrl;

  localparam int NL    = 4;
  localparam int PB    = 4;
  localparam int PS    = 2;
  localparam int BB    = 8;
  localparam int FRAME = PS * (1 << PB);

  logic          okClk = 1'b0;
  logic          rst;
  logic [2*NL-1:0]  cfg_mode;
  logic [PB*NL-1:0] cfg_duty;
  logic [BB-1:0]    cfg_blink_half;
  logic          cfg_update;
  logic          frame_start;
  logic          cfg_pending;
  logic [NL-1:0] led_on;

  led_pattern_ctrl #(.NUM_LED(NL), .PWM_BITS(PB), .PRESCALE(PS), .BLINK_BITS(BB)) dut (
    .okClk(okClk), .rst(rst), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .cfg_blink_half(cfg_blink_half), .cfg_update(cfg_update),
    .frame_start(frame_start), .cfg_pending(cfg_pending), .led_on(led_on)
  );

  always #5 okClk = ~okClk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [NL-1:0] led; logic fs; logic pend; } exp_t;
  exp_t q[$];

  int   ecount;          // edges since reset release
  bit   pv;              // model pending flag
  logic [2*NL-1:0]  pm, am;
  logic [PB*NL-1:0] pd;
  logic [BB-1:0]    ph, ah;
  int   ad [NL];         // effective active duty per channel
  int   apply_edge;
  logic [NL-1:0] next_led;

  function automatic int eff_duty(input int d);
`ifdef LED_PATTERN_GAMMA_EN
    if (d == (1 << PB) - 1) return d;
    return (d * d) / (1 << PB);
`else
    return d;
`endif
  endfunction

  function automatic logic [NL-1:0] model_led(input int c);
    logic [NL-1:0] r;
    int pwm_now, t, h, m;
    bit ph_hi;
    pwm_now = (c / PS) % (1 << PB);
    h = (ah == 0) ? 1 : int'(ah);
    t = (c - apply_edge) / PS;
    ph_hi = (apply_edge < 0) ? 1'b1 : (((t / h) % 2) == 0);
    for (int i = 0; i < NL; i++) begin
      m = int'(am[2*i +: 2]);
      case (m)
        1: r[i] = 1'b1;
        2: r[i] = ph_hi;
        3: r[i] = (pwm_now < ad[i]) || (ad[i] == (1 << PB) - 1);
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Model: advance the timeline each edge and queue the outputs expected
  // to be visible after that edge.
  initial begin
    exp_t e;
    bit boundary;
    forever begin
      @(posedge okClk);
      if (rst) begin
        ecount = 0; pv = 0; pm = '0; am = '0; pd = '0; ph = '0; ah = '0;
        for (int i = 0; i < NL; i++) ad[i] = 0;
        apply_edge = -1; next_led = '0;
        q.delete();
      end else begin
        e.led = next_led;
        ecount++;
        boundary = (ecount % FRAME) == 0;
        if (boundary && pv) begin
          am = pm; ah = ph; apply_edge = ecount; pv = 0;
          for (int i = 0; i < NL; i++) ad[i] = eff_duty(int'(pd[i*PB +: PB]));
        end
        if (cfg_update) begin
          pm = cfg_mode; pd = cfg_duty; ph = cfg_blink_half; pv = 1;
        end
        e.fs = boundary;
        e.pend = pv;
        q.push_back(e);
        next_led = model_led(ecount);
      end
    end
  end

  // Monitor: compare DUT outputs against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge okClk);
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        check("led_on", int'(led_on), int'(e.led));
        check("frame_start", int'(frame_start), int'(e.fs));
        check("cfg_pending", int'(cfg_pending), int'(e.pend));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic scramble();
    cfg_mode = 8'($urandom); cfg_duty = 16'($urandom); cfg_blink_half = 8'($urandom);
  endtask

  task automatic do_update(input logic [2*NL-1:0] m, input logic [PB*NL-1:0] d, input logic [BB-1:0] h);
    @(negedge okClk);
    cfg_mode = m; cfg_duty = d; cfg_blink_half = h; cfg_update = 1'b1;
    @(negedge okClk);
    cfg_update = 1'b0;
    scramble();
  endtask

  task automatic wait_fs();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge okClk);
      seen = frame_start;
    end
    check("wait_frame_start", int'(seen), 1);
  endtask

  task automatic first_fs_after_release();
    int n = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge okClk);
      n++;
      seen = frame_start;
    end
    check("first_frame_start_delay", n, FRAME);
  endtask

  task automatic count_high(input int ch, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge okClk);
      cnt += int'(led_on[ch]);
    end
  endtask

  function automatic int exp_high(input int d);
    int e = eff_duty(d);
    return PS * ((e == (1 << PB) - 1) ? (1 << PB) : e);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int cnt, miss;
    int duties [4] = '{4, 0, 15, 8};
    rst = 1'b1; cfg_update = 1'b0; cfg_mode = '0; cfg_duty = '0; cfg_blink_half = '0;
    repeat (3) @(negedge okClk);
    #1;
    check("reset_led_on", int'(led_on), 0);
    check("reset_pending", int'(cfg_pending), 0);
    check("reset_frame_start", int'(frame_start), 0);
    #1 rst = 1'b0;
    first_fs_after_release();

    // Static modes: ch3 on, ch2 off, ch1 on, ch0 on.
    do_update(8'b01_00_01_01, 16'h0000, 8'h00);
    wait_fs(); wait_fs();
    miss = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge okClk);
      if (led_on !== 4'b1011) miss++;
    end
    check("static_hold_cycles_wrong", miss, 0);

    // PWM duty sweep on ch0.
    foreach (duties[k]) begin
      do_update(8'b00_00_00_11, 16'(duties[k]), 8'h00);
      wait_fs(); wait_fs();
      count_high(0, FRAME, cnt);
      check($sformatf("pwm_high_cycles_duty%0d", duties[k]), cnt, exp_high(duties[k]));
    end

    // Blink on ch1 with half-period 3 ticks.
    do_update(8'b00_00_10_00, 16'h0000, 8'd3);
    wait_fs(); wait_fs();
    count_high(1, 12 * 4, cnt);
    check("blink_high_cycles", cnt, 24);

    // Update collision: duty 2 then 9 in one frame, third update on the boundary.
    wait_fs();
    do_update(8'b00_00_00_11, 16'd2, 8'h00);
    repeat (3) @(negedge okClk);
    do_update(8'b00_00_00_11, 16'd9, 8'h00);
    for (int i = 0; i < 2 * FRAME && (ecount % FRAME) != FRAME - 1; i++) @(negedge okClk);
    cfg_mode = 8'b00_00_00_11; cfg_duty = 16'd5; cfg_update = 1'b1;
    @(negedge okClk);
    cfg_update = 1'b0;
    scramble();
    check("collision_frame_start", int'(frame_start), 1);
    check("collision_pending_kept", int'(cfg_pending), 1);
    count_high(0, FRAME, cnt);
    check("collision_duty9_applied", cnt, exp_high(9));
    wait_fs();
    count_high(0, FRAME, cnt);
    check("collision_third_applied", cnt, exp_high(5));

    // Randomized configurations and update timing.
    for (int it = 0; it < 120; it++) begin
      repeat ($urandom_range(0, 40)) @(negedge okClk);
      do_update(8'($urandom), 16'($urandom), 8'($urandom_range(0, 5)));
    end
    repeat (2 * FRAME) @(negedge okClk);

    // Mid-run reset with ch0 on and a config pending.
    do_update(8'b00_00_00_01, 16'h0000, 8'h00);
    wait_fs(); wait_fs();
    do_update(8'b00_00_00_11, 16'h0007, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset_led_on", int'(led_on), 0);
    check("midrun_reset_pending", int'(cfg_pending), 0);
    check("midrun_reset_frame_start", int'(frame_start), 0);
    repeat (3) @(negedge okClk);
    #2 rst = 1'b0;
    first_fs_after_release();
    repeat (2 * FRAME) @(negedge okClk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
